// File: rtl/max7219_spi_tx_if.sv
// rtl/max7219_spi_tx_if.sv - request/status and pin bundle between sequencer, serializer and MAX7219
interface max7219_spi_tx_if;
    logic       str;
    logic [7:0] IRreg;
    logic [7:0] data;
    logic       busy;
    logic       done;
    logic       CS;
    logic       CLK;
    logic       Din;

    modport master (
        output str, IRreg, data,
        input  busy, done, CS, CLK, Din
    );

    modport slave (
        input  str, IRreg, data,
        output busy, done, CS, CLK, Din
    );
endinterface

// File: rtl/max7219_spi_tx.sv
// rtl/max7219_spi_tx.sv - 16-bit MAX7219 frame serializer (address then data, MSB first)
module max7219_spi_tx #(
    parameter int SYS_FREQ_KHZ = 50000,
    parameter int SPI_FREQ_KHZ = 12
) (
    input  logic                    sys_clk,
    input  logic                    rst,
    max7219_spi_tx_if.slave         bus
);
    localparam int H_RAW = SYS_FREQ_KHZ / (2 * SPI_FREQ_KHZ);
    localparam int H     = (H_RAW < 1) ? 1 : H_RAW;
    localparam int DW    = (H > 1) ? $clog2(H) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(H - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEAD  = 3'd1,
        CLKH  = 3'd2,
        CLKL  = 3'd3,
        LATCH = 3'd4,
        GAP   = 3'd5
    } state_t;

    state_t      state_q;
    logic [DW-1:0] div_q;
    logic [DW-1:0] div_d;
    logic        div_last;
    logic [3:0]  bitcnt_q;
    logic [15:0] sh_q;
    logic        cs_q;
    logic        clk_q;
    logic        din_q;
    logic        busy_q;
    logic        done_q;

    // Every non-IDLE state lasts exactly H sys_clk cycles.
    assign div_last = (div_q == DIV_LAST);
    assign div_d    = div_last ? '0 : div_q + DW'(1);

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q  <= IDLE;
            div_q    <= '0;
            bitcnt_q <= 4'd0;
            sh_q     <= 16'd0;
            cs_q     <= 1'b1;
            clk_q    <= 1'b0;
            din_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    div_q <= '0;
                    if (bus.str) begin
                        sh_q     <= {bus.IRreg, bus.data};
                        bitcnt_q <= 4'd15;
                        cs_q     <= 1'b0;
                        din_q    <= bus.IRreg[7];
                        busy_q   <= 1'b1;
                        state_q  <= LEAD;
                    end
                end
                LEAD: begin
                    div_q <= div_d;
                    if (div_last) begin
                        clk_q   <= 1'b1;
                        state_q <= CLKH;
                    end
                end
                CLKH: begin
                    div_q <= div_d;
                    if (div_last) begin
                        clk_q <= 1'b0;
                        if (bitcnt_q == 4'd0) begin
                            state_q <= LATCH;
                        end else begin
                            // Next bit goes out together with the falling CLK edge.
                            bitcnt_q <= bitcnt_q - 4'd1;
                            din_q    <= sh_q[bitcnt_q - 4'd1];
                            state_q  <= CLKL;
                        end
                    end
                end
                CLKL: begin
                    div_q <= div_d;
                    if (div_last) begin
                        clk_q   <= 1'b1;
                        state_q <= CLKH;
                    end
                end
                LATCH: begin
                    div_q <= div_d;
                    if (div_last) begin
                        cs_q    <= 1'b1;
                        state_q <= GAP;
                    end
                end
                GAP: begin
                    div_q <= div_d;
                    if (div_last) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        din_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    div_q    <= '0;
                    bitcnt_q <= 4'd0;
                    cs_q     <= 1'b1;
                    clk_q    <= 1'b0;
                    din_q    <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.CS   = cs_q;
    assign bus.CLK  = clk_q;
    assign bus.Din  = din_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_max7219_spi_tx.sv
// tb/tb_max7219_spi_tx.sv - randomized self-checking bench for max7219_spi_tx with a pin-level frame model
module tb_max7219_spi_tx;
    localparam int H        = 2;
    localparam int BUSY_LEN = 34 * H;

    logic sys_clk = 1'b0;
    logic rst;
    max7219_spi_tx_if bus();

    max7219_spi_tx #(.SYS_FREQ_KHZ(8), .SPI_FREQ_KHZ(2)) dut (
        .sys_clk (sys_clk),
        .rst     (rst),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pin-level observer: rebuilds each frame from Din at CLK rises and measures level widths.
    logic [15:0] mon_word;
    int          mon_rises, run, viol, busyrun, lowrun, dones;
    logic        p_cs, p_clk, p_din, p_busy;
    logic [15:0] cap_word[$];
    int          cap_rises[$];
    int          busy_len[$];
    int          low_run[$];
    logic [15:0] exp_q[$];

    initial begin
        mon_word = 16'd0; mon_rises = 0; run = 0; viol = 0;
        busyrun = 0; lowrun = 0; dones = 0;
        p_cs = 1'b1; p_clk = 1'b0; p_din = 1'b0; p_busy = 1'b0;
    end

    always @(negedge sys_clk) begin
        if (rst) begin
            mon_word = 16'd0; mon_rises = 0; run = 0; busyrun = 0; lowrun = 0;
        end else begin
            if (p_cs && !bus.CS) begin
                mon_word = 16'd0;
                mon_rises = 0;
            end
            if (!p_cs && bus.CS) begin
                if (run != H) viol++;
                cap_word.push_back(mon_word);
                cap_rises.push_back(mon_rises);
            end
            if (bus.CLK != p_clk) begin
                if (!p_cs && run != H) viol++;
                run = 1;
                if (bus.CLK) begin
                    mon_word = {mon_word[14:0], bus.Din};
                    mon_rises++;
                end
            end else begin
                run++;
            end
            if (p_cs && !bus.CS) run = 1;
            if (bus.CLK && bus.Din != p_din) viol++;
            if (bus.busy) begin
                if (!p_busy) low_run.push_back(lowrun);
                busyrun++;
                lowrun = 0;
            end else begin
                if (p_busy) busy_len.push_back(busyrun);
                busyrun = 0;
                lowrun++;
            end
            if (bus.done) begin
                dones++;
                if (!(p_busy && !bus.busy)) viol++;
            end
        end
        p_cs = bus.CS; p_clk = bus.CLK; p_din = bus.Din; p_busy = bus.busy;
    end

    task automatic tick();
        @(negedge sys_clk);
        #1;
    endtask

    task automatic drive_edge();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 4 * BUSY_LEN && !seen; i++) begin
            tick();
            if (bus.done) seen = 1'b1;
        end
        if (!seen) chk("timeout_done", 0, 1);
    endtask

    task automatic wait_busy();
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (bus.busy) seen = 1'b1;
        end
        if (!seen) chk("timeout_busy", 0, 1);
    endtask

    task automatic start_frame(input logic [7:0] ir, input logic [7:0] dt);
        drive_edge();
        bus.IRreg = ir; bus.data = dt; bus.str = 1'b1;
        exp_q.push_back({ir, dt});
        drive_edge();
        bus.str = 1'b0;
    endtask

    task automatic check_frames();
        chk("frame_count", cap_word.size(), exp_q.size());
        while (cap_word.size() > 0 && exp_q.size() > 0) begin
            chk("frame_bits", cap_word.pop_front(), exp_q.pop_front());
            chk("clk_rises", cap_rises.pop_front(), 16);
        end
        while (busy_len.size() > 0) chk("busy_len", busy_len.pop_front(), BUSY_LEN);
        cap_word.delete(); cap_rises.delete(); exp_q.delete();
    endtask

    initial begin
        int d0;
        logic [7:0] ir, dt;

        // Reset held with str asserted: pins stay idle.
        rst = 1'b1; bus.str = 1'b1; bus.IRreg = 8'h5A; bus.data = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_cs", bus.CS, 1);
            chk("rst_clk", bus.CLK, 0);
            chk("rst_din", bus.Din, 0);
            chk("rst_busy", bus.busy, 0);
            chk("rst_done", bus.done, 0);
        end
        drive_edge();
        rst = 1'b0; bus.str = 1'b0;
        repeat (3) tick();
        chk("idle_cs", bus.CS, 1);

        // Single frame 0x0C01 with accept latency check.
        d0 = dones;
        drive_edge();
        bus.IRreg = 8'h0C; bus.data = 8'h01; bus.str = 1'b1;
        exp_q.push_back(16'h0C01);
        tick();
        chk("busy_before_accept", bus.busy, 0);
        drive_edge();
        bus.str = 1'b0;
        tick();
        chk("busy_after_accept", bus.busy, 1);
        chk("cs_after_accept", bus.CS, 0);
        wait_done();
        chk("busy_at_done", bus.busy, 0);
        repeat (4) tick();
        chk("done_once", dones - d0, 1);
        check_frames();

        // Second frame for timing observation.
        start_frame(8'h03, 8'h7E);
        wait_done();
        repeat (3) tick();
        check_frames();
        chk("timing_frame2", viol, 0);

        // Start while busy is ignored; inputs changed mid-frame are not used.
        d0 = dones;
        start_frame(8'h0C, 8'h01);
        repeat (20) tick();
        drive_edge();
        bus.str = 1'b1; bus.IRreg = 8'hFF; bus.data = 8'hFF;
        drive_edge();
        bus.str = 1'b0;
        wait_done();
        repeat (80) tick();
        chk("ignore_busy", bus.busy, 0);
        chk("ignore_dones", dones - d0, 1);
        check_frames();

        // Back-to-back frames with str held.
        d0 = dones;
        low_run.delete();
        drive_edge();
        bus.IRreg = 8'd1; bus.data = 8'($urandom); bus.str = 1'b1;
        exp_q.push_back({bus.IRreg, bus.data});
        wait_busy();
        for (int f = 2; f <= 3; f++) begin
            drive_edge();
            bus.IRreg = 8'(f); bus.data = 8'($urandom);
            exp_q.push_back({bus.IRreg, bus.data});
            wait_done();
            wait_busy();
        end
        drive_edge();
        bus.str = 1'b0;
        wait_done();
        repeat (5) tick();
        chk("b2b_dones", dones - d0, 3);
        chk("b2b_rises", low_run.size(), 3);
        if (low_run.size() == 3) begin
            chk("b2b_gap1", low_run[1], 1);
            chk("b2b_gap2", low_run[2], 1);
        end
        check_frames();

        // Abort after the 7th CLK rise.
        d0 = dones;
        drive_edge();
        bus.IRreg = 8'h0A; bus.data = 8'h0F; bus.str = 1'b1;
        drive_edge();
        bus.str = 1'b0;
        begin
            bit hit = 1'b0;
            for (int i = 0; i < 200 && !hit; i++) begin
                tick();
                if (mon_rises == 7) hit = 1'b1;
            end
            if (!hit) chk("timeout_rise7", 0, 1);
        end
        drive_edge();
        rst = 1'b1;
        tick();
        tick();
        chk("abort_cs", bus.CS, 1);
        chk("abort_clk", bus.CLK, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        drive_edge();
        rst = 1'b0;
        repeat (3) tick();
        chk("abort_no_done", dones - d0, 0);
        start_frame(8'h0B, 8'h07);
        wait_done();
        repeat (3) tick();
        check_frames();

        // Random frames with mid-frame input disturbance and random idle gaps.
        for (int n = 0; n < 6; n++) begin
            ir = 8'($urandom);
            dt = 8'($urandom);
            start_frame(ir, dt);
            repeat ($urandom_range(5, 50)) tick();
            drive_edge();
            bus.IRreg = 8'($urandom); bus.data = 8'($urandom);
            wait_done();
            repeat ($urandom_range(0, 4)) drive_edge();
        end
        repeat (5) tick();
        check_frames();
        chk("timing_all", viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
